// File: rtl/gpio_sr_pkg.sv
// Shared types and constants for the 74HC595 serial output stage.
package gpio_sr_pkg;

  localparam int FRAME_W = 24;

  // Active-low segment codes, bit order {dp,g,f,e,d,c,b,a}; dp stays off.
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [9:0][7:0] SEG_DIGITS = {
    8'h90, 8'h80, 8'hF8, 8'h82, 8'h92,
    8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SHIFT_LO = 2'd1,
    ST_SHIFT_HI = 2'd2,
    ST_LATCH    = 2'd3
  } sr_state_t;

endpackage

// File: rtl/seg7_dec.sv
// Combinational 4-bit value to active-low 7-segment code; 10..15 blank.
module seg7_dec (
  input  logic [3:0] i_hex,
  output logic [7:0] o_seg
);
  import gpio_sr_pkg::*;

  // Table lookup with blank for non-decimal values.
  always_comb begin
    o_seg = SEG_BLANK;
    case (i_hex)
      4'd0:    o_seg = SEG_DIGITS[0];
      4'd1:    o_seg = SEG_DIGITS[1];
      4'd2:    o_seg = SEG_DIGITS[2];
      4'd3:    o_seg = SEG_DIGITS[3];
      4'd4:    o_seg = SEG_DIGITS[4];
      4'd5:    o_seg = SEG_DIGITS[5];
      4'd6:    o_seg = SEG_DIGITS[6];
      4'd7:    o_seg = SEG_DIGITS[7];
      4'd8:    o_seg = SEG_DIGITS[8];
      4'd9:    o_seg = SEG_DIGITS[9];
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/gpio_sr_drv.sv
// Serialises two digits and six lamps into a 24-bit frame for a chain of
// three 74HC595s. Frames go out after reset and on content change.
// Optional periodic resend: define GPIO_SR_REFRESH_EN.
//
// state       | meaning
// ST_IDLE     | waiting for a pending frame, sr_clk low
// ST_SHIFT_LO | sr_clk low, sr_data presents frame[bit_idx]
// ST_SHIFT_HI | sr_clk high, 595 samples sr_data
// ST_LATCH    | sr_latch high, frame copied to 595 outputs
module gpio_sr_drv #(
  parameter int CLK_DIV     = 25,
  parameter int REFRESH_CYC = 5_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] hex0n,
  input  logic [3:0] hex1n,
  input  logic       rled0,
  input  logic       gled0,
  input  logic       yled0,
  input  logic       rled1,
  input  logic       gled1,
  input  logic       yled1,
  output logic       sr_data,
  output logic       sr_clk,
  output logic       sr_latch,
  output logic       busy
);
  import gpio_sr_pkg::*;

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  if (CLK_DIV < 1 || REFRESH_CYC < 1) begin : g_param_chk
    $error("gpio_sr_drv: CLK_DIV and REFRESH_CYC must be >= 1");
  end

  logic [7:0]         w_seg0, w_seg1;
  logic [FRAME_W-1:0] w_enc;
  logic               w_pending, w_start, w_div_tc, w_ref_req;

  sr_state_t          r_state, w_state_nxt;
  logic [FRAME_W-1:0] r_frame, w_frame_nxt;
  logic [FRAME_W-1:0] r_sent, w_sent_nxt;
  logic               r_force, w_force_nxt;
  logic [4:0]         r_bit_idx, w_bit_idx_nxt;
  logic [DW-1:0]      r_div_cnt, w_div_nxt;

  seg7_dec u_seg0 (.i_hex(hex0n), .o_seg(w_seg0));
  seg7_dec u_seg1 (.i_hex(hex1n), .o_seg(w_seg1));

  assign w_enc = {w_seg1, w_seg0, 2'b00, yled1, gled1, rled1, yled0, gled0, rled0};
  assign w_div_tc  = (r_div_cnt == DIV_LAST);
  assign w_pending = r_force | (w_enc != r_sent) | w_ref_req;

`ifdef GPIO_SR_REFRESH_EN
  localparam int RW = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_CYC - 1);
  logic [RW-1:0] r_ref_cnt;
  logic          r_ref_req;

  // Free-running refresh timer; a request waits in r_ref_req until a frame starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ref_cnt <= '0;
      r_ref_req <= 1'b0;
    end else if (w_start) begin
      r_ref_cnt <= '0;
      r_ref_req <= 1'b0;
    end else if (r_ref_cnt == REF_LAST) begin
      r_ref_cnt <= '0;
      r_ref_req <= 1'b1;
    end else begin
      r_ref_cnt <= r_ref_cnt + 1'b1;
    end
  end
  assign w_ref_req = r_ref_req;
`else
  assign w_ref_req = 1'b0;
`endif

  // Next-state and datapath updates for the shift sequencer.
  always_comb begin
    w_state_nxt   = r_state;
    w_frame_nxt   = r_frame;
    w_sent_nxt    = r_sent;
    w_force_nxt   = r_force;
    w_bit_idx_nxt = r_bit_idx;
    w_div_nxt     = r_div_cnt;
    w_start       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pending) begin
          w_frame_nxt   = w_enc;
          w_bit_idx_nxt = 5'd23;
          w_div_nxt     = '0;
          w_state_nxt   = ST_SHIFT_LO;
          w_start       = 1'b1;
        end
      end
      ST_SHIFT_LO: begin
        if (w_div_tc) begin
          w_div_nxt   = '0;
          w_state_nxt = ST_SHIFT_HI;
        end else begin
          w_div_nxt = r_div_cnt + 1'b1;
        end
      end
      ST_SHIFT_HI: begin
        if (w_div_tc) begin
          w_div_nxt = '0;
          if (r_bit_idx == 5'd0) begin
            w_state_nxt = ST_LATCH;
          end else begin
            w_bit_idx_nxt = r_bit_idx - 5'd1;
            w_state_nxt   = ST_SHIFT_LO;
          end
        end else begin
          w_div_nxt = r_div_cnt + 1'b1;
        end
      end
      ST_LATCH: begin
        if (w_div_tc) begin
          w_div_nxt   = '0;
          w_sent_nxt  = r_frame;
          w_force_nxt = 1'b0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_div_nxt = r_div_cnt + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State registers plus outputs registered from the next state so pins are glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_frame   <= '0;
      r_sent    <= '0;
      r_force   <= 1'b1;
      r_bit_idx <= '0;
      r_div_cnt <= '0;
      sr_data   <= 1'b0;
      sr_clk    <= 1'b0;
      sr_latch  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_frame   <= w_frame_nxt;
      r_sent    <= w_sent_nxt;
      r_force   <= w_force_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_div_cnt <= w_div_nxt;
      sr_clk    <= (w_state_nxt == ST_SHIFT_HI);
      sr_latch  <= (w_state_nxt == ST_LATCH);
      busy      <= (w_state_nxt != ST_IDLE);
      // Data moves only when a low half-period begins: full setup and hold around sr_clk rise.
      if (w_state_nxt == ST_SHIFT_LO && r_state != ST_SHIFT_LO)
        sr_data <= w_frame_nxt[w_bit_idx_nxt];
    end
  end

endmodule

// File: tb/tb_gpio_sr_drv.sv
// Scoreboard bench for gpio_sr_drv with CLK_DIV=2: expected frames are queued
// when inputs change and compared against what the serial monitor captures.
module tb_gpio_sr_drv;

  localparam int CLK_DIV = 2;
  localparam int FRAME_CYC = 49 * CLK_DIV;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] hex0n, hex1n;
  logic rled0, gled0, yled0, rled1, gled1, yled1;
  logic sr_data, sr_clk, sr_latch, busy;

  int checks = 0;
  int failures = 0;

  logic [23:0] exp_q[$];

  // monitor state
  logic [23:0] shreg = '0;
  int nbits = 0;
  int sr_edges = 0;
  int n_latch = 0;
  int busy_len = 0;
  int latch_len = 0;
  int gap_cnt = 0;
  int last_gap = -1;
  logic p_clk = 1'b0, p_latch = 1'b0, p_busy = 1'b0;

  gpio_sr_drv #(.CLK_DIV(CLK_DIV), .REFRESH_CYC(5_000_000)) dut (
    .clk(clk), .rst(rst),
    .hex0n(hex0n), .hex1n(hex1n),
    .rled0(rled0), .gled0(gled0), .yled0(yled0),
    .rled1(rled1), .gled1(gled1), .yled1(yled1),
    .sr_data(sr_data), .sr_clk(sr_clk), .sr_latch(sr_latch), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] seg_m(input logic [3:0] d);
    case (d)
      4'd0: return 8'hC0;  4'd1: return 8'hF9;  4'd2: return 8'hA4;
      4'd3: return 8'hB0;  4'd4: return 8'h99;  4'd5: return 8'h92;
      4'd6: return 8'h82;  4'd7: return 8'hF8;  4'd8: return 8'h80;
      4'd9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [23:0] frame_m();
    return {seg_m(hex1n), seg_m(hex0n), 2'b00, yled1, gled1, rled1, yled0, gled0, rled0};
  endfunction

  // Serial monitor: rebuilds the frame from sr_clk rises, scores it on sr_latch.
  always @(negedge clk) begin
    if (rst) begin
      nbits = 0; busy_len = 0; latch_len = 0; gap_cnt = 0;
    end else begin
      if (sr_clk && !p_clk) begin
        shreg = {shreg[22:0], sr_data};
        nbits++;
        sr_edges++;
      end
      if (sr_latch && !p_latch) begin
        n_latch++;
        if (exp_q.size() == 0) chk("unexpected_latch", 1, 0);
        else chk("frame", shreg, exp_q.pop_front());
        chk("bits_per_frame", nbits, 24);
        nbits = 0;
      end
      if (sr_latch) latch_len++;
      if (!sr_latch && p_latch) begin
        chk("latch_width", latch_len, CLK_DIV);
        latch_len = 0;
      end
      if (busy && !p_busy) begin
        last_gap = gap_cnt;
        gap_cnt = 0;
      end
      if (busy) busy_len++;
      else gap_cnt++;
      if (!busy && p_busy) begin
        chk("busy_len", busy_len, FRAME_CYC);
        busy_len = 0;
      end
    end
    p_clk = sr_clk; p_latch = sr_latch; p_busy = busy;
  end

  task automatic wait_latch(input int target, input int budget);
    int n = 0;
    while (n_latch < target && n < budget) begin
      @(negedge clk); n++;
    end
    chk("latch_count", n_latch, target);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk); n++;
    end
    chk("idle_reached", busy, 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n;
    int e0, l0;
    rst = 1'b1;
    hex0n = 4'd0; hex1n = 4'd0;
    rled0 = 0; gled0 = 0; yled0 = 0; rled1 = 0; gled1 = 0; yled1 = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sr_data", sr_data, 0);
    chk("rst_sr_clk", sr_clk, 0);
    chk("rst_sr_latch", sr_latch, 0);
    chk("rst_busy", busy, 0);
    chk("model_all_zero", frame_m(), 24'hC0C000);

    // frame after reset
    exp_q.push_back(frame_m());
    rst = 1'b0;
    wait_latch(1, 400);
    wait_idle(100);

    // mixed digits and lamps
    hex1n = 4'd9; hex0n = 4'd3; gled1 = 1; rled0 = 1;
    chk("model_90B011", frame_m(), 24'h90B011);
    exp_q.push_back(frame_m());
    wait_latch(2, 400);
    wait_idle(100);

    // blank digit
    hex0n = 4'd12;
    exp_q.push_back(frame_m());
    wait_latch(3, 400);
    wait_idle(100);

    // held inputs: nothing more is sent
    e0 = sr_edges; l0 = n_latch;
    repeat (1000) @(negedge clk);
    chk("quiet_sr_edges", sr_edges - e0, 0);
    chk("quiet_latches", n_latch - l0, 0);
    chk("quiet_busy", busy, 0);

    // change in the middle of a transfer
    hex0n = 4'd5;
    exp_q.push_back(frame_m());
    n = 0;
    while (nbits < 10 && n < 400) begin
      @(negedge clk); n++;
    end
    chk("reached_bit10", nbits >= 10, 1);
    hex0n = 4'd7; yled0 = 1;
    exp_q.push_back(frame_m());
    wait_latch(5, 800);
    wait_idle(100);
    chk("idle_gap", last_gap, 1);

    // reset during a high half-period
    hex0n = 4'd1; yled1 = 1;
    exp_q.push_back(frame_m());
    n = 0;
    while (!(sr_clk && nbits >= 4) && n < 400) begin
      @(negedge clk); n++;
    end
    chk("reached_shift_hi", sr_clk, 1);
    l0 = n_latch;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_sr_data", sr_data, 0);
    chk("abort_sr_clk", sr_clk, 0);
    chk("abort_sr_latch", sr_latch, 0);
    chk("abort_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_no_latch", n_latch - l0, 0);
    wait_latch(l0 + 1, 400);
    wait_idle(100);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
